// File: rtl/uart_tx_sched.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte
// requesters. It issues a one-cycle start pulse and holds the byte and the
// owner id steady for the whole frame. It follows the frame through the
// uart_ctrl done level, then inserts a programmable idle gap.
module uart_tx_sched #(
  parameter int NUM_REQ  = 4,
  parameter int IDW      = 3,
  parameter int BUSY_TMO = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mpi_uart_en,
  input  logic [15:0]          cfg_gap,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 usr_start_tx,
  output logic [7:0]           usr_data_tx,
  input  logic                 usr_done_tx,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy,
  output logic                 err_timeout
);

  // The timeout counter only has to reach BUSY_TMO-1.
  localparam int TW = (BUSY_TMO < 2) ? 1 : $clog2(BUSY_TMO);
  localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TMO - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_BUSY = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_GAP       = 2'd3
  } state_t;

  state_t               state_q;
  logic [IDW-1:0]       ptr_q;
  logic [IDW-1:0]       grant_q;
  logic [7:0]           data_q;
  logic [NUM_REQ-1:0]   ready_q;
  logic                 start_q;
  logic                 busy_q;
  logic                 err_q;
  logic [TW-1:0]        tmo_q;
  logic [15:0]          gap_q;

  logic                 win_found_d;
  logic [IDW-1:0]       win_idx_d;
  logic [7:0]           win_byte_d;
  logic [NUM_REQ-1:0]   win_onehot_d;

  // Round-robin search from ptr+1 upward, wrapping. Indices above the pointer
  // take precedence over indices at or below it, and the lowest index wins
  // inside each region. The pointer itself is therefore the last candidate.
  always_comb begin
    win_found_d = 1'b0;
    win_idx_d   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (i <= int'(ptr_q))) begin
        win_found_d = 1'b1;
        win_idx_d   = IDW'(i);
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (i > int'(ptr_q))) begin
        win_found_d = 1'b1;
        win_idx_d   = IDW'(i);
      end
    end
  end

  // Byte and one-hot ready mask of the winning requester.
  always_comb begin
    win_byte_d   = '0;
    win_onehot_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx_d == IDW'(i)) begin
        win_byte_d      = req_data[8*i +: 8];
        win_onehot_d[i] = 1'b1;
      end
    end
  end

  // Scheduler FSM. All outputs are registered in this block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= IDW'(NUM_REQ - 1);
      grant_q <= '0;
      data_q  <= '0;
      ready_q <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
      gap_q   <= '0;
    end else begin
      ready_q <= '0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (mpi_uart_en && win_found_d) begin
            data_q  <= win_byte_d;
            grant_q <= win_idx_d;
            ready_q <= win_onehot_d;
            start_q <= 1'b1;
            ptr_q   <= win_idx_d;
            tmo_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          // uart_ctrl keeps done high for a couple of cycles after start.
          // The byte is dropped, not retried, if done never falls.
          if (!usr_done_tx) begin
            state_q <= S_WAIT_DONE;
          end else if (tmo_q == TMO_LAST) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          // The frame length depends on the baud divider, so there is no timeout here.
          if (usr_done_tx) begin
            if (cfg_gap == 16'd0) begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              gap_q   <= cfg_gap;
              state_q <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (gap_q == 16'd1) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            gap_q <= gap_q - 16'd1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready    = ready_q;
  assign usr_start_tx = start_q;
  assign usr_data_tx  = data_q;
  assign grant_id     = grant_q;
  assign busy         = busy_q;
  assign err_timeout  = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched. It applies a vector table of cycle-by-cycle inputs
// and expected outputs, then runs hand-written multi-cycle sequences against
// a small uart_ctrl done-level model.
module tb_uart_tx_sched;

  localparam int NUM_REQ  = 4;
  localparam int IDW      = 3;
  localparam int BUSY_TMO = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              mpi_uart_en = 1'b0;
  logic [15:0]       cfg_gap = '0;
  logic [3:0]        req_valid = '0;
  logic [31:0]       req_data = 32'hC3B2A15A;
  logic [3:0]        req_ready;
  logic              usr_start_tx;
  logic [7:0]        usr_data_tx;
  logic              usr_done_tx = 1'b1;
  logic [IDW-1:0]    grant_id;
  logic              busy;
  logic              err_timeout;

  uart_tx_sched #(.NUM_REQ(NUM_REQ), .IDW(IDW), .BUSY_TMO(BUSY_TMO)) dut (
    .clk(clk), .rst_n(rst_n), .mpi_uart_en(mpi_uart_en), .cfg_gap(cfg_gap),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .usr_start_tx(usr_start_tx), .usr_data_tx(usr_data_tx),
    .usr_done_tx(usr_done_tx), .grant_id(grant_id), .busy(busy),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Requesters hold valid until ready.
  assert property (@(posedge clk) disable iff (!rst_n)
    (($past(req_valid) & ~req_valid & ~req_ready) == 4'b0000))
    else $error("protocol: valid withdrawn before ready");

  typedef struct {
    logic        rst;
    logic        en;
    logic [3:0]  vld;
    logic        done;
    logic [15:0] gap;
    logic [3:0]  rdy;
    logic        st;
    logic [7:0]  dtx;
    logic [2:0]  gid;
    logic        bsy;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  // uart_ctrl model: done falls 2 cycles after start and rises 100 cycles later.
  bit mdl_on = 0;
  bit auto_drop = 0;
  int m_cnt = 0;
  int rise_cyc = 0;
  bit overlap = 0;
  logic [31:0] dat = 32'hC3B2A15A;

  task automatic add(input logic r, input logic e, input logic [3:0] v,
                     input logic d, input logic [15:0] g, input logic [3:0] rdy,
                     input logic st, input logic [7:0] dtx, input logic [2:0] gid,
                     input logic bsy, input logic err);
    vec_t x;
    x.rst = r; x.en = e; x.vld = v; x.done = d; x.gap = g;
    x.rdy = rdy; x.st = st; x.dtx = dtx; x.gid = gid; x.bsy = bsy; x.err = err;
    tbl.push_back(x);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] out_bus();
    return {14'd0, req_ready, usr_start_tx, usr_data_tx, grant_id, busy, err_timeout};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (mdl_on) begin
      if (usr_start_tx) begin
        if (m_cnt != 0) overlap = 1;
        m_cnt = 1;
      end else if (m_cnt != 0) begin
        m_cnt++;
      end
      if (m_cnt == 3) usr_done_tx = 1'b0;
      if (m_cnt == 103) begin
        usr_done_tx = 1'b1;
        m_cnt = 0;
        rise_cyc = cyc;
      end
    end
    if (auto_drop) req_valid = req_valid & ~req_ready;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; usr_done_tx = 1'b1; m_cnt = 0;
    rise_cyc = 0; overlap = 0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int k, bad, t0, b10, b11, g, err_at, err_n, nxt_at, nxt_gid, n_st, sp_bad;
    int exp_rr[5];
    exp_rr = '{0, 1, 2, 3, 0};

    // ---------------- vector table ----------------
    //   rst en  vld    done gap   rdy    st dtx    gid bsy err
    add(0, 0, 4'h0, 1, 0,  4'h0, 0, 8'h00, 0, 0, 0); // reset state
    add(1, 0, 4'h8, 1, 0,  4'h0, 0, 8'h00, 0, 0, 0); // enable low gates
    add(1, 0, 4'h8, 1, 0,  4'h0, 0, 8'h00, 0, 0, 0);
    add(1, 1, 4'h8, 1, 0,  4'h8, 1, 8'hC3, 3, 1, 0); // grant 3
    add(1, 1, 4'h0, 1, 0,  4'h0, 0, 8'hC3, 3, 1, 0); // wait busy
    add(1, 1, 4'h0, 0, 0,  4'h0, 0, 8'hC3, 3, 1, 0); // -> wait done
    add(1, 1, 4'h0, 0, 0,  4'h0, 0, 8'hC3, 3, 1, 0);
    add(1, 1, 4'h0, 1, 2,  4'h0, 0, 8'hC3, 3, 1, 0); // done, gap=2
    add(1, 1, 4'h0, 1, 5,  4'h0, 0, 8'hC3, 3, 1, 0); // gap 2 -> 1
    add(1, 1, 4'h1, 1, 5,  4'h0, 0, 8'hC3, 3, 0, 0); // gap end, valid ignored
    add(1, 1, 4'h1, 1, 0,  4'h1, 1, 8'h5A, 0, 1, 0); // grant 0, wrap from 3
    for (int i = 0; i < BUSY_TMO - 1; i++)
      add(1, 1, 4'h0, 1, 0, 4'h0, 0, 8'h5A, 0, 1, 0); // done stuck high
    add(1, 1, 4'h0, 1, 0,  4'h0, 0, 8'h5A, 0, 0, 1); // timeout pulse
    add(1, 1, 4'h1, 1, 0,  4'h1, 1, 8'h5A, 0, 1, 0); // self-grant at pointer
    add(1, 0, 4'h0, 0, 0,  4'h0, 0, 8'h5A, 0, 1, 0); // en drop mid-frame
    add(1, 0, 4'h0, 1, 0,  4'h0, 0, 8'h5A, 0, 0, 0); // frame still completes
    add(1, 0, 4'h2, 1, 0,  4'h0, 0, 8'h5A, 0, 0, 0);
    add(1, 0, 4'h2, 1, 0,  4'h0, 0, 8'h5A, 0, 0, 0);
    add(1, 1, 4'h2, 1, 0,  4'h2, 1, 8'hA1, 1, 1, 0); // grant 1
    add(1, 1, 4'h0, 1, 0,  4'h0, 0, 8'hA1, 1, 1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst_n = tbl[i].rst; mpi_uart_en = tbl[i].en; req_valid = tbl[i].vld;
      usr_done_tx = tbl[i].done; cfg_gap = tbl[i].gap;
      tick();
      check($sformatf("vec%0d", i), out_bus(),
            {14'd0, tbl[i].rdy, tbl[i].st, tbl[i].dtx, tbl[i].gid, tbl[i].bsy, tbl[i].err});
    end

    // ---------------- single byte ----------------
    do_reset();
    mdl_on = 1; auto_drop = 1; mpi_uart_en = 1; cfg_gap = 0;
    req_valid = 4'b0001;
    tick();
    check("single_start", {usr_start_tx, req_ready, usr_data_tx, 1'b0, grant_id},
          {1'b1, 4'b0001, 8'h5A, 1'b0, 3'd0});
    k = 0; bad = 0;
    while (rise_cyc == 0 && k < 300) begin
      tick(); k++;
      if (rise_cyc == 0 && (usr_start_tx || req_ready != 0 || usr_data_tx != 8'h5A || !busy))
        bad++;
    end
    check("single_hold", {k >= 300, 31'(bad)}, 0);
    tick();
    check("single_idle", {busy, usr_data_tx, grant_id}, {1'b0, 8'h5A, 3'd0});

    // ---------------- round robin ----------------
    do_reset();
    mdl_on = 1; auto_drop = 0; cfg_gap = 0; req_valid = 4'b1111;
    k = 0; n_st = 0; sp_bad = 0;
    while (n_st < 5 && k < 1000) begin
      tick(); k++;
      if (usr_start_tx) begin
        check($sformatf("rr%0d", n_st), {req_ready, 1'b0, grant_id, usr_data_tx},
              {4'(1 << exp_rr[n_st]), 1'b0, 3'(exp_rr[n_st]), dat[8*exp_rr[n_st] +: 8]});
        if (n_st > 0 && cyc - rise_cyc != 2) sp_bad++;
        n_st++;
      end else if (req_ready != 0) begin
        sp_bad++;
      end
    end
    check("rr_done", {k >= 1000, 31'(n_st)}, 5);
    check("rr_spacing", {overlap, 31'(sp_bad)}, 0);

    // ---------------- gap ----------------
    do_reset();
    mdl_on = 1; auto_drop = 1; cfg_gap = 10; req_valid = 4'b0011;
    tick();
    check("gap_first", {usr_start_tx, grant_id}, {1'b1, 3'd0});
    k = 0; b10 = -1; b11 = -1;
    while (!(usr_start_tx && rise_cyc != 0) && k < 400) begin
      tick(); k++;
      if (rise_cyc != 0 && cyc == rise_cyc + 10) b10 = busy;
      if (rise_cyc != 0 && cyc == rise_cyc + 11) b11 = busy;
    end
    check("gap_second", {usr_start_tx, grant_id, 28'(cyc - rise_cyc)}, {1'b1, 3'd1, 28'd12});
    check("gap_busy", {b10 == 1, b11 == 0}, 2'b11);

    // ---------------- timeout ----------------
    do_reset();
    mdl_on = 0; auto_drop = 1; cfg_gap = 0; usr_done_tx = 1'b1; req_valid = 4'b0101;
    tick();
    g = cyc;
    check("tmo_grant", {req_ready, 1'b0, grant_id}, {4'b0001, 1'b0, 3'd0});
    k = 0; err_at = -1; err_n = 0; nxt_at = -1; nxt_gid = -1;
    while (nxt_at < 0 && k < 40) begin
      tick(); k++;
      if (err_timeout) begin
        err_n++;
        if (err_at < 0) err_at = cyc - g;
      end
      if (usr_start_tx) begin
        nxt_at = cyc - g;
        nxt_gid = grant_id;
      end
    end
    check("tmo_err", {8'(err_at), 8'(err_n)}, {8'(BUSY_TMO), 8'd1});
    check("tmo_next", {8'(nxt_at), 8'(nxt_gid)}, {8'(BUSY_TMO + 1), 8'd2});

    // ---------------- reset mid-frame ----------------
    do_reset();
    mdl_on = 1; auto_drop = 1; cfg_gap = 0; req_valid = 4'b0010;
    tick();
    check("rst_grant", {usr_start_tx, grant_id}, {1'b1, 3'd1});
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0;
    tick();
    check("rst_mid", out_bus(), 0);
    m_cnt = 0; usr_done_tx = 1'b1;
    rst_n = 1'b1; req_valid = 4'b0101;
    tick();
    check("rst_prio", {usr_start_tx, req_ready, 1'b0, grant_id}, {1'b1, 4'b0001, 1'b0, 3'd0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
